// File: rtl/vector_op_engine.sv
// vector_op_engine: streams n elements of a and b over one AVMM master, writes op(a,b) to c or reduces a+b.
module vector_op_engine #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  input  logic                stall,
  input  logic [1:0]          op,
  input  logic [ADDR_W-1:0]   a,
  input  logic [ADDR_W-1:0]   b,
  input  logic [ADDR_W-1:0]   c,
  input  logic [CNT_W-1:0]    n,
  output logic [DATA_W-1:0]   result,
  output logic                sat_flag,
  output logic [ADDR_W-1:0]   avmm_0_rw_address,
  output logic [DATA_W/8-1:0] avmm_0_rw_byteenable,
  output logic                avmm_0_rw_read,
  output logic                avmm_0_rw_write,
  output logic [DATA_W-1:0]   avmm_0_rw_writedata,
  input  logic [DATA_W-1:0]   avmm_0_rw_readdata,
  input  logic                avmm_0_rw_waitrequest,
  input  logic                avmm_0_rw_readdatavalid
);
  typedef enum logic [2:0] {IDLE, RD_A, WT_A, RD_B, WT_B, WR_C, FIN} state_e;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] a_base_q, a_base_d, b_base_q, b_base_d, c_base_q, c_base_d, off;
  logic [CNT_W-1:0]  n_q, n_d, i_q, i_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, acc_q, acc_d, wd_q, wd_d, sum, diff, sat_v;
  logic              sat_q, sat_d, wr_ok, rdv, last, ovf, a_take, b_take, reduce;
  state_e            after_b, after_el;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      a_base_q <= '0;
      b_base_q <= '0;
      c_base_q <= '0;
      n_q      <= '0;
      i_q      <= '0;
      op_q     <= '0;
      a_q      <= '0;
      acc_q    <= '0;
      wd_q     <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
      c_base_q <= c_base_d;
      n_q      <= n_d;
      i_q      <= i_d;
      op_q     <= op_d;
      a_q      <= a_d;
      acc_q    <= acc_d;
      wd_q     <= wd_d;
      sat_q    <= sat_d;
    end
  end
  // Read data landing on the accepting edge is taken directly, skipping the WT state.
  always_comb begin
    wr_ok    = !avmm_0_rw_waitrequest;
    rdv      = avmm_0_rw_readdatavalid;
    reduce   = op_q == 2'b11;
    last     = i_q == n_q - CNT_W'(1);
    a_take   = (state_q == RD_A && wr_ok && rdv) || (state_q == WT_A && rdv);
    b_take   = (state_q == RD_B && wr_ok && rdv) || (state_q == WT_B && rdv);
    sum      = a_q + avmm_0_rw_readdata;
    diff     = a_q - avmm_0_rw_readdata;
    ovf      = a_q[DATA_W-1] == avmm_0_rw_readdata[DATA_W-1] && sum[DATA_W-1] != a_q[DATA_W-1];
    sat_v    = !ovf ? sum : a_q[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    after_el = last ? FIN : RD_A;
    after_b  = reduce ? after_el : WR_C;
    state_d  = state_q;
    case (state_q)
      IDLE:    state_d = start ? (n == '0 ? FIN : RD_A) : IDLE;
      RD_A:    state_d = wr_ok ? (rdv ? RD_B : WT_A) : RD_A;
      WT_A:    state_d = rdv ? RD_B : WT_A;
      RD_B:    state_d = wr_ok ? (rdv ? after_b : WT_B) : RD_B;
      WT_B:    state_d = rdv ? after_b : WT_B;
      WR_C:    state_d = wr_ok ? after_el : WR_C;
      FIN:     state_d = stall ? FIN : IDLE;
      default: state_d = IDLE;
    endcase
    a_base_d = a_base_q;
    b_base_d = b_base_q;
    c_base_d = c_base_q;
    n_d      = n_q;
    op_d     = op_q;
    i_d      = i_q;
    acc_d    = acc_q;
    sat_d    = sat_q;
    a_d      = a_take ? avmm_0_rw_readdata : a_q;
    wd_d     = b_take && !reduce ? (op_q == 2'b00 ? sum : op_q == 2'b01 ? diff : sat_v) : wd_q;
    if (b_take && reduce) acc_d = acc_q + sum;
    if (b_take && op_q == 2'b10 && ovf) sat_d = 1'b1;
    if (((b_take && reduce) || (state_q == WR_C && wr_ok)) && !last) i_d = i_q + CNT_W'(1);
    if (state_q == IDLE && start) begin
      a_base_d = a;
      b_base_d = b;
      c_base_d = c;
      n_d      = n;
      op_d     = op;
      i_d      = '0;
      acc_d    = '0;
      sat_d    = 1'b0;
    end
  end
  always_comb begin
    off                  = ADDR_W'(i_q) * ADDR_W'(DATA_W / 8);
    busy                 = state_q != IDLE;
    done                 = state_q == FIN;
    avmm_0_rw_read       = state_q == RD_A || state_q == RD_B;
    avmm_0_rw_write      = state_q == WR_C;
    avmm_0_rw_address    = state_q == RD_A ? a_base_q + off :
                           state_q == RD_B ? b_base_q + off :
                           state_q == WR_C ? c_base_q + off : '0;
    avmm_0_rw_byteenable = avmm_0_rw_read || avmm_0_rw_write ? '1 : '0;
    avmm_0_rw_writedata  = wd_q;
    result               = acc_q;
    sat_flag             = sat_q;
  end
endmodule
